set_cond_ctrl: RTL
==================

# set_cond_ctrl

Multi-cycle controller that executes DLX set-condition instructions (SEQ, SNE, SLT, SGT, SLE, SGE, signed or unsigned, register or immediate second operand). It reads up to two operands through a shared register-file read port and compares them. It zero-extends the 1-bit outcome to 32 bits and writes it back through a write port arbitrated against the main pipeline. It sits beside the ALU and is started by the control unit once per set-instruction.

## Interface
Parameters:
- none; widths fixed at 32-bit data, 5-bit register addresses, 16-bit immediate.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle request; accepted only when BUSY=0.
- COND  in  3  000 EQ, 001 NE, 010 LT, 011 GT, 100 LE, 101 GE, 110/111 illegal.
- UNS  in  1  1 = unsigned compare, 0 = signed.
- IMM_SEL  in  1  1 = operand B is sign-extended IMM.
- RS1, RS2, RD  in  5 each  source/destination register numbers.
- IMM  in  16  immediate, sign-extended to 32 bits.
- RF_RADDR  out  5  read-port address.
- RF_RDATA  in  32  read-port data, combinational from RF_RADDR.
- RF_WREQ  out  1  write-port request.
- RF_WGNT  in  1  write-port grant from pipeline arbiter.
- RF_WE  out  1  write strobe = RF_WREQ & RF_WGNT.
- RF_WADDR  out  5  latched RD.
- RF_WDATA  out  32  {31'b0, result}.
- BUSY  out  1  high from cycle after START acceptance until the completing cycle inclusive.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  registered; high with DONE when COND was illegal.

## Operation
- States: IDLE, RD_A, RD_B, CMP, WB.
- IDLE: START=1 latches COND, UNS, IMM_SEL, RS1, RS2, RD, IMM; next RD_A. START while BUSY=1 is ignored, with no queuing.
- RD_A: RF_RADDR=RS1; capture RF_RDATA into OPA at edge. Next RD_B, or CMP if IMM_SEL=1, in which case OPB=sign-extended IMM.
- RD_B: RF_RADDR=RS2; capture into OPB; next CMP.
- CMP: compute result bit from OPA/OPB per COND/UNS; register it. Illegal COND yields result 0 and sets ERR. Next WB.
- WB: RF_WREQ=1 while waiting. The write completes in the first cycle with RF_WGNT=1: RF_WE=1 and DONE=1, then next IDLE. With RF_WGNT=0 the block stays in WB indefinitely.
- RD=0: no write request. WB completes immediately with DONE=1, RF_WE=0, RF_WREQ=0.
- Illegal COND with RD≠0: 0 is still written.
- RF_RADDR=0 outside read states.
- Compare rules:
  - Signed uses two's complement: 0x80000000 < 0x00000000.
  - Unsigned: 0xFFFFFFFF > 0x00000000.
  - EQ/NE ignore UNS.

## Timing
- Reset: state IDLE; BUSY, DONE, ERR, RF_WREQ, RF_WE = 0; RF_RADDR, RF_WADDR, RF_WDATA = 0. Latched fields cleared.
- RESET mid-operation aborts with no write and no DONE.
- Latency from START-accept edge to DONE cycle with grant present:
  - register form: 4 cycles (RD_A, RD_B, CMP, WB);
  - immediate form: 3 cycles.
- Each cycle of RF_WGNT=0 in WB adds one cycle.
- RF_WE, RF_WREQ and RF_RADDR decode from state and RF_WGNT; RF_RADDR may be combinational.
- A new START may be accepted in the cycle after DONE (IDLE), not in the DONE cycle.
- RF_WDATA and RF_WADDR are stable throughout WB.

## Structure
- Package dlx_setcond_pkg: COND encodings, state encoding constants, data/address width constants.
- Sub-module set_cond_cmp: combinational comparator producing the 1-bit result and an illegal flag from OPA, OPB, COND, UNS.
- The FSM, operand registers and zero-extension stay in set_cond_ctrl.

## Test plan
- Register SLT: R1=0xFFFFFFFF, R2=0x00000001, COND=010, UNS=0, RD=3, grant held → RF_WE in cycle 4 with RF_WADDR=3, RF_WDATA=0x00000001, DONE=1.
- Same operands with UNS=1 → RF_WDATA=0x00000000.
- Immediate SGE: R4=5, IMM=0xFFFB (−5), COND=101 → write 1 in cycle 3; RF_RADDR never shows RS2.
- Grant withheld 3 cycles in WB → RF_WREQ high 4 cycles, exactly one RF_WE/DONE; START pulses during BUSY are ignored.
- RD=0, and separately COND=110 with RD=7:
  - RD=0 → DONE with no RF_WE;
  - COND=110 → write 0 to R7 with ERR=1.
- RESET asserted in CMP → next cycle IDLE, all outputs 0, no write. A following START completes normally.

Source files
------------

// File: rtl/dlx_setcond_pkg.sv
// Shared constants for the DLX set-condition controller: widths, compare
// condition encodings, FSM state encoding and immediate sign extension.
// No logic, no latency, no flow control.
package dlx_setcond_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int IMM_W  = 16;

    // COND field encodings; 3'b110 and 3'b111 are illegal.
    typedef enum logic [2:0] {
        COND_EQ = 3'b000,
        COND_NE = 3'b001,
        COND_LT = 3'b010,
        COND_GT = 3'b011,
        COND_LE = 3'b100,
        COND_GE = 3'b101
    } cond_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_CMP  = 3'd3,
        ST_WB   = 3'd4
    } state_e;

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/set_cond_cmp.sv
// Combinational comparator: 1-bit set-condition result plus illegal-COND flag.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller registers the outputs.
// Ports: opa_i/opb_i operands, cond_i condition code, uns_i unsigned select,
//        res_o comparison outcome, illegal_o high for COND 110/111.
module set_cond_cmp
    import dlx_setcond_pkg::*;
(
    input  logic [DATA_W-1:0] opa_i,
    input  logic [DATA_W-1:0] opb_i,
    input  logic [2:0]        cond_i,
    input  logic              uns_i,
    output logic              res_o,
    output logic              illegal_o
);

    logic eq;
    logic lt;

    always_comb begin
        eq        = (opa_i == opb_i);
        // Equality is sign-agnostic; only the ordering depends on uns_i.
        lt        = uns_i ? (opa_i < opb_i) : ($signed(opa_i) < $signed(opb_i));
        res_o     = 1'b0;
        illegal_o = 1'b0;
        case (cond_i)
            COND_EQ: res_o = eq;
            COND_NE: res_o = ~eq;
            COND_LT: res_o = lt;
            COND_GT: res_o = ~lt & ~eq;
            COND_LE: res_o = lt | eq;
            COND_GE: res_o = ~lt;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/set_cond_ctrl.sv
// Multi-cycle DLX set-condition executor: read RS1 (and RS2), compare, write 0/1 to RD.
// Latency: START edge to DONE is 4 cycles (register form) or 3 (immediate form), +1 per withheld grant.
// Backpressure: waits in WB with RF_WREQ high until RF_WGNT; START while BUSY is dropped.
// Ports: START/COND/UNS/IMM_SEL/RS1/RS2/RD/IMM instruction fields; RF_RADDR/RF_RDATA read port;
//        RF_WREQ/RF_WGNT/RF_WE/RF_WADDR/RF_WDATA arbitrated write port; BUSY/DONE/ERR status.
module set_cond_ctrl
    import dlx_setcond_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [2:0]        COND,
    input  logic              UNS,
    input  logic              IMM_SEL,
    input  logic [REG_W-1:0]  RS1,
    input  logic [REG_W-1:0]  RS2,
    input  logic [REG_W-1:0]  RD,
    input  logic [IMM_W-1:0]  IMM,
    output logic [REG_W-1:0]  RF_RADDR,
    input  logic [DATA_W-1:0] RF_RDATA,
    output logic              RF_WREQ,
    input  logic              RF_WGNT,
    output logic              RF_WE,
    output logic [REG_W-1:0]  RF_WADDR,
    output logic [DATA_W-1:0] RF_WDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    state_e            state_q;
    logic [2:0]        cond_q;
    logic              uns_q;
    logic              imm_sel_q;
    logic [REG_W-1:0]  rs1_q;
    logic [REG_W-1:0]  rs2_q;
    logic [REG_W-1:0]  rd_q;
    logic [IMM_W-1:0]  imm_q;
    logic [DATA_W-1:0] opa_q;
    logic [DATA_W-1:0] opb_q;
    logic              res_q;
    logic              err_q;

    logic              cmp_res;
    logic              cmp_illegal;
    logic              wb_done;

    set_cond_cmp u_cmp (
        .opa_i     (opa_q),
        .opb_i     (opb_q),
        .cond_i    (cond_q),
        .uns_i     (uns_q),
        .res_o     (cmp_res),
        .illegal_o (cmp_illegal)
    );

    // R0 is never written, so WB retires immediately without asking for the port.
    assign wb_done = (state_q == ST_WB) && (RF_WGNT || (rd_q == '0));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cond_q    <= '0;
            uns_q     <= 1'b0;
            imm_sel_q <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            res_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        cond_q    <= COND;
                        uns_q     <= UNS;
                        imm_sel_q <= IMM_SEL;
                        rs1_q     <= RS1;
                        rs2_q     <= RS2;
                        rd_q      <= RD;
                        imm_q     <= IMM;
                        state_q   <= ST_RD_A;
                    end
                end
                ST_RD_A: begin
                    opa_q <= RF_RDATA;
                    if (imm_sel_q) begin
                        // Immediate form skips the second read-port cycle.
                        opb_q   <= sext_imm(imm_q);
                        state_q <= ST_CMP;
                    end else begin
                        state_q <= ST_RD_B;
                    end
                end
                ST_RD_B: begin
                    opb_q   <= RF_RDATA;
                    state_q <= ST_CMP;
                end
                ST_CMP: begin
                    res_q   <= cmp_res;
                    err_q   <= cmp_illegal;
                    state_q <= ST_WB;
                end
                ST_WB: begin
                    if (wb_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        RF_RADDR = '0;
        case (state_q)
            ST_RD_A: RF_RADDR = rs1_q;
            ST_RD_B: RF_RADDR = rs2_q;
            default: RF_RADDR = '0;
        endcase
    end

    assign BUSY     = (state_q != ST_IDLE);
    assign RF_WREQ  = (state_q == ST_WB) && (rd_q != '0);
    assign RF_WE    = RF_WREQ & RF_WGNT;
    assign RF_WADDR = rd_q;
    assign RF_WDATA = {{(DATA_W-1){1'b0}}, res_q};
    assign DONE     = wb_done;
    assign ERR      = wb_done & err_q;

endmodule
